// File: rtl/nm_pkg.sv
// Shared constants for the nibble comparator: widths, FSM encoding, comparator polarity.
package nm_pkg;

  localparam int NIBBLE_W = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } nm_state_e;

  // bm_selector value meaning "the A bit was the 1"
  localparam logic SEL_A_MAYOR = 1'b1;

  // SHIFT step at which the bit-0 result is on the comparator outputs
  localparam logic [2:0] LAST_STEP = 3'd4;

endpackage

// File: rtl/nm_serializador.sv
// Parallel-load MSB-first shifters for A and B; index k saturates at the last bit so bit 0 is held.
// Zero latency from load to MSB on bit_a/bit_b; shifts once per cycle while shift is high.
module nm_serializador
  import nm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic [NIBBLE_W-1:0] a_in,
  input  logic [NIBBLE_W-1:0] b_in,
  output logic                bit_a,
  output logic                bit_b
);

  logic [NIBBLE_W-1:0] sr_a;
  logic [NIBBLE_W-1:0] sr_b;
  logic [IDX_W-1:0]    k;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_a <= '0;
      sr_b <= '0;
      k    <= '0;
    end else if (load) begin
      sr_a <= a_in;
      sr_b <= b_in;
      k    <= '0;
    end else if (shift && (k != IDX_W'(NIBBLE_W - 1))) begin
      sr_a <= {sr_a[NIBBLE_W-2:0], 1'b0};
      sr_b <= {sr_b[NIBBLE_W-2:0], 1'b0};
      k    <= k + IDX_W'(1);
    end
  end

  assign bit_a = sr_a[NIBBLE_W-1];
  assign bit_b = sr_b[NIBBLE_W-1];

endmodule

// File: rtl/nibble_mayor.sv
// Picks the larger of two nibbles by streaming bit pairs MSB-first through an external registered comparator.
// nm_done 3..6 cycles after accept; nm_ready only in IDLE, so requests wait while busy.
module nibble_mayor
  import nm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                nm_valid,
  input  logic [NIBBLE_W-1:0] nm_a,
  input  logic [NIBBLE_W-1:0] nm_b,
  output logic                nm_ready,
  output logic                bm_a,
  output logic                bm_b,
  input  logic                bm_selector,
  input  logic                bm_distintos,
  output logic                nm_done,
  output logic [NIBBLE_W-1:0] nm_mayor,
  output logic                nm_a_mayor,
  output logic                nm_iguales
);

  nm_state_e           state;
  logic [2:0]          step;
  logic [NIBBLE_W-1:0] a_q;
  logic [NIBBLE_W-1:0] b_q;
  logic                accept;
  logic                in_shift;
  logic                ser_a;
  logic                ser_b;
  logic                sel_is_a;

  assign nm_ready = (state == ST_IDLE);
  assign accept   = nm_valid & nm_ready;
  assign in_shift = (state == ST_SHIFT);
  assign sel_is_a = (bm_selector == SEL_A_MAYOR);

  nm_serializador u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (in_shift),
    .a_in  (nm_a),
    .b_in  (nm_b),
    .bit_a (ser_a),
    .bit_b (ser_b)
  );

  assign bm_a = in_shift & ser_a;
  assign bm_b = in_shift & ser_b;

  // step 0 is the first SHIFT cycle: the comparator still shows stale data then
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      step       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      nm_done    <= 1'b0;
      nm_mayor   <= '0;
      nm_a_mayor <= 1'b0;
      nm_iguales <= 1'b0;
    end else begin
      nm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q   <= nm_a;
            b_q   <= nm_b;
            step  <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if ((step != 3'd0) && bm_distintos) begin
            nm_a_mayor <= sel_is_a;
            nm_iguales <= 1'b0;
            nm_mayor   <= sel_is_a ? a_q : b_q;
            nm_done    <= 1'b1;
            state      <= ST_DONE;
          end else if (step == LAST_STEP) begin
            nm_a_mayor <= 1'b0;
            nm_iguales <= 1'b1;
            nm_mayor   <= a_q;
            nm_done    <= 1'b1;
            state      <= ST_DONE;
          end else begin
            step <= step + 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_mayor.sv
// Bench for nibble_mayor with a registered bit comparator and an arithmetic reference model.
module tb_nibble_mayor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nm_valid = 1'b0;
  logic [3:0] nm_a = '0;
  logic [3:0] nm_b = '0;
  logic       nm_ready, bm_a, bm_b, nm_done, nm_a_mayor, nm_iguales;
  logic       bm_selector, bm_distintos;
  logic [3:0] nm_mayor;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_mayor dut (
    .clk          (clk),
    .reset        (reset),
    .nm_valid     (nm_valid),
    .nm_a         (nm_a),
    .nm_b         (nm_b),
    .nm_ready     (nm_ready),
    .bm_a         (bm_a),
    .bm_b         (bm_b),
    .bm_selector  (bm_selector),
    .bm_distintos (bm_distintos),
    .nm_done      (nm_done),
    .nm_mayor     (nm_mayor),
    .nm_a_mayor   (nm_a_mayor),
    .nm_iguales   (nm_iguales)
  );

  // registered bit comparator: result of the pair driven in cycle n visible in cycle n+1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bm_selector  <= 1'b0;
      bm_distintos <= 1'b0;
    end else begin
      bm_selector  <= bm_a & ~bm_b;
      bm_distintos <= bm_a ^ bm_b;
    end
  end

  // Issues one request from an IDLE cycle (called #1 after a rising edge); returns what was seen.
  // lat counts cycles after the accept cycle until nm_done; 0 means nm_done never came.
  task automatic do_req(input logic [3:0] a, input logic [3:0] b, output int lat,
                        output logic [3:0] m, output logic am, output logic ig,
                        output logic fa, output logic fb);
    nm_valid = 1'b1;
    nm_a = a;
    nm_b = b;
    @(posedge clk); #1;
    nm_valid = 1'b0;
    nm_a = 4'($urandom);
    nm_b = 4'($urandom);
    lat = 0; m = 'x; am = 1'bx; ig = 1'bx; fa = 1'bx; fb = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin fa = bm_a; fb = bm_b; end
      if (c == 2) nm_a = ~nm_a;
      if (nm_done === 1'b1) begin
        lat = c; m = nm_mayor; am = nm_a_mayor; ig = nm_iguales;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    nm_valid = 1'b1;
    nm_a = 4'h9;
    nm_b = 4'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 7;
    if (nm_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", nm_ready); end
    if (nm_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", nm_done); end
    if (bm_a !== 1'b0) begin n_bad++; $display("FAIL reset_bm_a: got %b want 0", bm_a); end
    if (bm_b !== 1'b0) begin n_bad++; $display("FAIL reset_bm_b: got %b want 0", bm_b); end
    if (nm_mayor !== 4'h0) begin n_bad++; $display("FAIL reset_mayor: got %h want 0", nm_mayor); end
    if (nm_a_mayor !== 1'b0) begin n_bad++; $display("FAIL reset_a_mayor: got %b want 0", nm_a_mayor); end
    if (nm_iguales !== 1'b0) begin n_bad++; $display("FAIL reset_iguales: got %b want 0", nm_iguales); end
    @(posedge clk); #1;
    nm_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [3:0] a_t[3] = '{4'h9, 4'h5, 4'hA};
    logic [3:0] b_t[3] = '{4'h7, 4'h6, 4'hA};
    int         l_t[3] = '{3, 5, 6};
    logic [3:0] m_t[3] = '{4'h9, 4'h6, 4'hA};
    logic       am_t[3] = '{1'b1, 1'b0, 1'b0};
    logic       ig_t[3] = '{1'b0, 1'b0, 1'b1};
    int lat; logic [3:0] m; logic am, ig, fa, fb;
    for (int i = 0; i < 3; i++) begin
      do_req(a_t[i], b_t[i], lat, m, am, ig, fa, fb);
      n_cmp += 6;
      if (lat != l_t[i]) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, l_t[i]); end
      if (m !== m_t[i]) begin n_bad++; $display("FAIL dir%0d_mayor: got %h want %h", i, m, m_t[i]); end
      if (am !== am_t[i]) begin n_bad++; $display("FAIL dir%0d_a_mayor: got %b want %b", i, am, am_t[i]); end
      if (ig !== ig_t[i]) begin n_bad++; $display("FAIL dir%0d_iguales: got %b want %b", i, ig, ig_t[i]); end
      if (fa !== a_t[i][3]) begin n_bad++; $display("FAIL dir%0d_first_bm_a: got %b want %b", i, fa, a_t[i][3]); end
      if (fb !== b_t[i][3]) begin n_bad++; $display("FAIL dir%0d_first_bm_b: got %b want %b", i, fb, b_t[i][3]); end
    end
  endtask

  task automatic test_random;
    int lat, exp_lat, hi;
    logic [3:0] a, b, m, exp_m, x;
    logic am, ig, fa, fb;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      b = (i % 5 == 0) ? a : 4'($urandom_range(0, 15));
      // reference: compare as integers; latency from the highest differing bit
      exp_m = (a >= b) ? a : b;
      x = a ^ b;
      hi = -1;
      for (int j = 0; j < 4; j++) if (x[j]) hi = j;
      exp_lat = (hi < 0) ? 6 : 3 + (3 - hi);
      do_req(a, b, lat, m, am, ig, fa, fb);
      n_cmp += 6;
      if (lat != exp_lat) begin n_bad++; $display("FAIL rnd%0d_latency a=%h b=%h: got %0d want %0d", i, a, b, lat, exp_lat); end
      if (m !== exp_m) begin n_bad++; $display("FAIL rnd%0d_mayor a=%h b=%h: got %h want %h", i, a, b, m, exp_m); end
      if (am !== (a > b)) begin n_bad++; $display("FAIL rnd%0d_a_mayor a=%h b=%h: got %b want %b", i, a, b, am, (a > b)); end
      if (ig !== (a == b)) begin n_bad++; $display("FAIL rnd%0d_iguales a=%h b=%h: got %b want %b", i, a, b, ig, (a == b)); end
      @(negedge clk);
      if (nm_done !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_done_width: got %b want 0", i, nm_done); end
      if (nm_mayor !== exp_m) begin n_bad++; $display("FAIL rnd%0d_hold_mayor: got %h want %h", i, nm_mayor, exp_m); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i <= 12; i++) begin
      case (i)
        0: begin nm_valid = 1'b1; nm_a = 4'h3; nm_b = 4'hC; end
        1: nm_a = 4'h5;
        2: begin nm_a = 4'hF; nm_b = 4'hF; end
        10: nm_valid = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      n_cmp++;
      if (i == 3 || i == 10) begin
        if (nm_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_c%0d: got %b want 1", i, nm_done); end
        n_cmp += 3;
        if (nm_mayor !== ((i == 3) ? 4'hC : 4'hF)) begin n_bad++; $display("FAIL b2b_mayor_c%0d: got %h", i, nm_mayor); end
        if (nm_a_mayor !== 1'b0) begin n_bad++; $display("FAIL b2b_a_mayor_c%0d: got %b want 0", i, nm_a_mayor); end
        if (nm_iguales !== (i == 10)) begin n_bad++; $display("FAIL b2b_iguales_c%0d: got %b want %b", i, nm_iguales, (i == 10)); end
      end else if (nm_done !== 1'b0) begin
        n_bad++; $display("FAIL b2b_spurious_done_c%0d: got %b want 0", i, nm_done);
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (nm_ready !== (i == 4)) begin n_bad++; $display("FAIL b2b_ready_c%0d: got %b want %b", i, nm_ready, (i == 4)); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic [3:0] m; logic am, ig, fa, fb, saw;
    nm_valid = 1'b1; nm_a = 4'h2; nm_b = 4'h1;
    @(posedge clk); #1;
    nm_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp += 7;
    if (nm_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", nm_ready); end
    if (nm_done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", nm_done); end
    if (bm_a !== 1'b0) begin n_bad++; $display("FAIL abort_bm_a: got %b want 0", bm_a); end
    if (bm_b !== 1'b0) begin n_bad++; $display("FAIL abort_bm_b: got %b want 0", bm_b); end
    if (nm_mayor !== 4'h0) begin n_bad++; $display("FAIL abort_mayor: got %h want 0", nm_mayor); end
    if (nm_a_mayor !== 1'b0) begin n_bad++; $display("FAIL abort_a_mayor: got %b want 0", nm_a_mayor); end
    if (nm_iguales !== 1'b0) begin n_bad++; $display("FAIL abort_iguales: got %b want 0", nm_iguales); end
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (nm_done === 1'b1) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", saw); end
    @(posedge clk); #1;
    reset = 1'b1;
    do_req(4'h1, 4'h2, lat, m, am, ig, fa, fb);
    n_cmp += 4;
    if (lat != 5) begin n_bad++; $display("FAIL post_reset_latency: got %0d want 5", lat); end
    if (m !== 4'h2) begin n_bad++; $display("FAIL post_reset_mayor: got %h want 2", m); end
    if (am !== 1'b0) begin n_bad++; $display("FAIL post_reset_a_mayor: got %b want 0", am); end
    if (ig !== 1'b0) begin n_bad++; $display("FAIL post_reset_iguales: got %b want 0", ig); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_mayor.md
NIBBLE_MAYOR -- requirements
Module: nibble_mayor

Interface
REQ-001 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; reset=0 SHALL clear all state immediately.
REQ-003 nm_valid  in  1  request; nm_a/nm_b are valid while high.
REQ-004 nm_a  in  4  nibble A.
REQ-005 nm_b  in  4  nibble B.
REQ-006 nm_ready  out  1  high when a request can be accepted.
REQ-007 bm_a  out  1  bit of A driven to the downstream bit comparator, MSB first.
REQ-008 bm_b  out  1  bit of B driven to the bit comparator, same index as bm_a.
REQ-009 bm_selector  in  1  comparator result: 1 = bm_a bit was the 1 (A larger at that bit).
REQ-010 bm_distintos  in  1  comparator result: 1 = bit pair differed.
REQ-011 nm_done  out  1  one-cycle pulse; result outputs valid.
REQ-012 nm_mayor  out  4  larger nibble; equal case returns nm_a.
REQ-013 nm_a_mayor  out  1  1 = A > B.
REQ-014 nm_iguales  out  1  1 = A == B.

Function
REQ-015 Comparator contract: the result for the pair driven in cycle n SHALL be present on bm_selector/bm_distintos during cycle n+1 (one-cycle registered latency).
REQ-016 FSM states: IDLE, SHIFT, DONE; encoding 2 bits, IDLE = 0.
REQ-017 nm_ready SHALL be 1 only in IDLE.
REQ-018 Accept = nm_valid & nm_ready at edge ending cycle T; A and B latched; bit index k cleared; IDLE->SHIFT.
REQ-019 SHIFT: cycle T+1+k drives bm_a=A[3-k], bm_b=B[3-k] for k=0..3; k saturates at 3 (bit 0 held).
REQ-020 SHIFT: comparator results SHALL be sampled from cycle T+2 onward; results for pairs driven before T+1 ignored.
REQ-021 First sampled result with bm_distintos=1 decides: nm_a_mayor=bm_selector, nm_iguales=0, nm_mayor=latched A if selector else latched B; SHIFT->DONE.
REQ-022 No distinct result after the bit-0 result (cycle T+5): nm_iguales=1, nm_a_mayor=0, nm_mayor=A; SHIFT->DONE.
REQ-023 Latency: decision on bit 3-k SHALL assert nm_done in cycle T+3+k; equal case in T+6.
REQ-024 DONE: nm_done=1 for exactly one cycle; DONE->IDLE unconditionally.
REQ-025 bm_a/bm_b SHALL be 0 in IDLE and DONE; results arriving in DONE/IDLE ignored.
REQ-026 nm_mayor/nm_a_mayor/nm_iguales SHALL hold their values from DONE until the next decision.
REQ-027 nm_valid or nm_a/nm_b changes while not in IDLE SHALL have no effect.
REQ-028 nm_valid held high: next accept SHALL occur in the IDLE cycle following DONE (throughput one request per 3..6+1 cycles).

Reset
REQ-029 reset=0 SHALL force IDLE, k=0, latched A/B=0, nm_ready=1, nm_done=0, bm_a=bm_b=0, nm_mayor=0, nm_a_mayor=0, nm_iguales=0.
REQ-030 Reset mid-SHIFT SHALL abort without nm_done; first accept possible at first edge with reset=1.

Structure
REQ-031 Package nm_pkg SHALL hold NIBBLE_W=4, state encodings, and the selector polarity constant.
REQ-032 Sub-module nm_serializador SHALL hold the two 4-bit parallel-load MSB-first shift registers and index k; FSM and result registers stay in nibble_mayor.

Verification
REQ-033 The bench SHALL connect the team's registered bit comparator to bm_a/bm_b/bm_selector/bm_distintos.
REQ-034 A=4'h9, B=4'h7, accept at T -> bm_a/bm_b=1/0 at T+1, nm_done at T+3, nm_mayor=9, nm_a_mayor=1, nm_iguales=0.
REQ-035 A=4'h5, B=4'h6 -> decision on bit 1, nm_done at T+5, nm_mayor=6, nm_a_mayor=0.
REQ-036 A=B=4'hA -> nm_done at T+6, nm_iguales=1, nm_mayor=A, nm_a_mayor=0.
REQ-037 nm_valid held high, pairs (3,C) then (F,F) -> second accept in cycle after first nm_done, results C/0/0 then F/0/1; nm_a changed mid-SHIFT leaves result unchanged.
REQ-038 reset=0 at T+2 of A=2,B=1 -> outputs per REQ-029 immediately, no nm_done; after release A=1,B=2 -> nm_mayor=2 at T'+5.
